// File: rtl/pipe_mcu_pkg.sv
// Shared types and helpers for the MCU issue controller and its scoreboard.
package pipe_mcu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } mcu_state_t;

    localparam int unsigned MCU_LAT_DEFAULT = 4;

    // Width of a down-counter that is loaded with lat-1.
    function automatic int unsigned lat_cnt_w(input int unsigned lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/pipe_pending_table.sv
// Per-register pending bits for the in-flight MCU op, with one set port, one
// clear port and three combinational lookup ports.
module pipe_pending_table #(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic [AW-1:0] i_ra1_idx,
    input  logic [AW-1:0] i_ra2_idx,
    input  logic [AW-1:0] i_rd_idx,
    output logic          o_ra1_pend,
    output logic          o_ra2_pend,
    output logic          o_rd_pend
);

    logic [NREG-1:0] r_pending;

    // Indices at or above NREG match no entry, so they read as not pending.
    function automatic logic lookup(input logic [NREG-1:0] vec, input logic [AW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (idx == AW'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (i_set_en && (i_set_idx == AW'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (i_clr_en && (i_clr_idx == AW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_ra1_pend = lookup(r_pending, i_ra1_idx);
        o_ra2_pend = lookup(r_pending, i_ra2_idx);
        o_rd_pend  = lookup(r_pending, i_rd_idx);
    end

endmodule

// File: rtl/pipe_mcu_scoreboard.sv
// Issue controller for the shared multi-cycle unit: accepts one op, sequences
// its latency, arbitrates the write port and raises StallMD for hazards.
module pipe_mcu_scoreboard
    import pipe_mcu_pkg::*;
#(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4,
    parameter int unsigned LAT  = MCU_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          IssueD,
    input  logic [AW-1:0] RdD,
    input  logic [AW-1:0] Ra1D,
    input  logic [AW-1:0] Ra2D,
    input  logic          RdUseD,
    input  logic          Ra1UseD,
    input  logic          Ra2UseD,
    input  logic          FlushD,
    input  logic          RegWriteW,
    output logic          StallMD,
    output logic          McuStartE,
    output logic          McuWrW,
    output logic [AW-1:0] McuRdW,
    output logic          McuBusy
);

    localparam int unsigned     CW       = lat_cnt_w(LAT);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LAT - 1);

    mcu_state_t    r_state;
    mcu_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_start;
    logic [AW-1:0] r_rd;

    logic          w_accept;
    logic          w_in_wb;
    logic          w_mcu_wr;
    logic          w_ra1_raw;
    logic          w_ra2_raw;
    logic          w_rd_raw;
    logic          w_ra1_pend;
    logic          w_ra2_pend;
    logic          w_rd_pend;

    pipe_pending_table #(
        .NREG (NREG),
        .AW   (AW)
    ) u_pending (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_set_en   (w_accept),
        .i_set_idx  (RdD),
        .i_clr_en   (w_mcu_wr),
        .i_clr_idx  (r_rd),
        .i_ra1_idx  (Ra1D),
        .i_ra2_idx  (Ra2D),
        .i_rd_idx   (RdD),
        .o_ra1_pend (w_ra1_raw),
        .o_ra2_pend (w_ra2_raw),
        .o_rd_pend  (w_rd_raw)
    );

    // The pipeline always wins the write port; the MCU only writes when it is free.
    assign w_in_wb  = (r_state == WB);
    assign w_mcu_wr = w_in_wb & ~RegWriteW;

    // A register being written back this cycle is readable (first-half write).
    assign w_ra1_pend = w_ra1_raw & ~(w_mcu_wr & (r_rd == Ra1D));
    assign w_ra2_pend = w_ra2_raw & ~(w_mcu_wr & (r_rd == Ra2D));
    assign w_rd_pend  = w_rd_raw  & ~(w_mcu_wr & (r_rd == RdD));

    always_comb begin
        StallMD = (IssueD & (r_state != IDLE))
                | (Ra1UseD & w_ra1_pend)
                | (Ra2UseD & w_ra2_pend)
                | (RdUseD & w_rd_pend)
                | w_in_wb;
        w_accept = (r_state == IDLE) & IssueD & ~FlushD & ~StallMD;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WB;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WB: begin
                if (w_mcu_wr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_accept;
            if (w_accept) begin
                r_rd <= RdD;
            end
        end
    end

    assign McuStartE = r_start;
    assign McuWrW    = w_mcu_wr;
    assign McuRdW    = r_rd;
    assign McuBusy   = (r_state != IDLE);

endmodule

// File: tb/tb_pipe_mcu_scoreboard.sv
// Drives two scoreboards (LAT=4/NREG=16 and LAT=1/NREG=12) with directed and
// random traffic and checks every output each cycle against an op-age model.
module tb_pipe_mcu_scoreboard;

    localparam int unsigned AW    = 4;
    localparam int unsigned NREG0 = 16;
    localparam int unsigned LAT0  = 4;
    localparam int unsigned NREG1 = 12;
    localparam int unsigned LAT1  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          IssueD = 1'b0;
    logic [AW-1:0] RdD = '0;
    logic [AW-1:0] Ra1D = '0;
    logic [AW-1:0] Ra2D = '0;
    logic          RdUseD = 1'b0;
    logic          Ra1UseD = 1'b0;
    logic          Ra2UseD = 1'b0;
    logic          FlushD = 1'b0;
    logic          RegWriteW = 1'b0;

    logic [1:0]    stall_o;
    logic [1:0]    start_o;
    logic [1:0]    wr_o;
    logic [1:0]    busy_o;
    logic [AW-1:0] rdw0;
    logic [AW-1:0] rdw1;

    pipe_mcu_scoreboard #(.NREG(NREG0), .AW(AW), .LAT(LAT0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .IssueD(IssueD), .RdD(RdD), .Ra1D(Ra1D), .Ra2D(Ra2D),
        .RdUseD(RdUseD), .Ra1UseD(Ra1UseD), .Ra2UseD(Ra2UseD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .StallMD(stall_o[0]), .McuStartE(start_o[0]),
        .McuWrW(wr_o[0]), .McuRdW(rdw0), .McuBusy(busy_o[0])
    );

    pipe_mcu_scoreboard #(.NREG(NREG1), .AW(AW), .LAT(LAT1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .IssueD(IssueD), .RdD(RdD), .Ra1D(Ra1D), .Ra2D(Ra2D),
        .RdUseD(RdUseD), .Ra1UseD(Ra1UseD), .Ra2UseD(Ra2UseD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .StallMD(stall_o[1]), .McuStartE(start_o[1]),
        .McuWrW(wr_o[1]), .McuRdW(rdw1), .McuBusy(busy_o[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          armed = 1'b0;

    // Model: an op is either in flight or not; age counts cycles since accept.
    int lat_m[2]  = '{LAT0, LAT1};
    int nreg_m[2] = '{NREG0, NREG1};
    bit m_act[2]  = '{0, 0};
    int m_age[2]  = '{0, 0};
    int m_rd[2]   = '{0, 0};
    bit n_act[2];
    int n_age[2];
    int n_rd[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend_m(input int d, input int r, input bit wr_now);
        return m_act[d] && (m_rd[d] == r) && (r < nreg_m[d]) && !wr_now;
    endfunction

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit in_wb, wr_e, stall_e, acc;
            in_wb   = m_act[d] && (m_age[d] >= lat_m[d] + 1);
            wr_e    = in_wb && !RegWriteW;
            stall_e = (IssueD && m_act[d])
                   || (Ra1UseD && pend_m(d, int'(Ra1D), wr_e))
                   || (Ra2UseD && pend_m(d, int'(Ra2D), wr_e))
                   || (RdUseD && pend_m(d, int'(RdD), wr_e))
                   || in_wb;
            if (armed) begin
                check_val($sformatf("stall%0d", d), 32'(stall_o[d]), 32'(stall_e));
                check_val($sformatf("start%0d", d), 32'(start_o[d]), 32'(m_act[d] && m_age[d] == 1));
                check_val($sformatf("wr%0d", d), 32'(wr_o[d]), 32'(wr_e));
                check_val($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(m_act[d]));
                check_val($sformatf("rdw%0d", d), 32'((d == 0) ? rdw0 : rdw1), 32'(m_rd[d]));
            end
            acc = !m_act[d] && IssueD && !FlushD && !stall_e;
            n_act[d] = m_act[d];
            n_age[d] = m_age[d];
            n_rd[d]  = m_rd[d];
            if (!reset_n) begin
                n_act[d] = 1'b0;
                n_age[d] = 0;
                n_rd[d]  = 0;
            end else if (wr_e) begin
                n_act[d] = 1'b0;
            end else if (m_act[d]) begin
                n_age[d] = m_age[d] + 1;
            end else if (acc) begin
                n_act[d] = 1'b1;
                n_age[d] = 1;
                n_rd[d]  = int'(RdD);
            end
        end
        @(posedge clk);
        #1;
        if (!reset_n) armed = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = n_act[d];
            m_age[d] = n_age[d];
            m_rd[d]  = n_rd[d];
        end
    endtask

    task automatic set_in(input bit iss, input int rd, input int r1, input int r2,
                          input bit rdu, input bit r1u, input bit r2u,
                          input bit fl, input bit rw, input bit rn);
        IssueD    = iss;
        RdD       = AW'(rd);
        Ra1D      = AW'(r1);
        Ra2D      = AW'(r2);
        RdUseD    = rdu;
        Ra1UseD   = r1u;
        Ra2UseD   = r2u;
        FlushD    = fl;
        RegWriteW = rw;
        reset_n   = rn;
    endtask

    initial begin
        // Reset, then a single issue to r3 with a dependent reader behind it.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        set_in(1, 3, 0, 0, 1, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 3, 0, 0, 1, 0, 0, 0, 1);
        repeat (7) cycle();

        // Write-port conflict: pipeline holds the port for two WB cycles.
        set_in(1, 5, 0, 0, 1, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 5, 0, 0, 1, 0, 0, 1);
        repeat (4) cycle();
        set_in(0, 0, 0, 5, 0, 0, 1, 0, 1, 1);
        repeat (2) cycle();
        set_in(0, 0, 0, 5, 0, 0, 1, 0, 0, 1);
        repeat (3) cycle();

        // Back-to-back issue while busy, then a flushed issue in IDLE.
        set_in(1, 7, 0, 0, 1, 0, 0, 0, 0, 1);
        cycle();
        set_in(1, 8, 0, 0, 1, 0, 0, 0, 0, 1);
        repeat (3) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (8) cycle();
        set_in(1, 9, 0, 0, 1, 0, 0, 1, 0, 1);
        cycle();
        set_in(0, 0, 9, 9, 0, 1, 1, 0, 0, 1);
        repeat (2) cycle();

        // Reset in the second BUSY cycle abandons the op.
        set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 2, 0, 0, 1, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 2, 0, 0, 1, 0, 0, 0, 1);
        repeat (8) cycle();

        // Boundary registers: 11 (last entry of NREG=12), 15, 13 (ignored by NREG=12).
        foreach (m_rd[k]) begin end
        for (int j = 0; j < 3; j++) begin
            int r;
            r = (j == 0) ? 11 : (j == 1) ? 15 : 13;
            set_in(1, r, 0, 0, 0, 0, 0, 0, 0, 1);
            cycle();
            set_in(0, 0, r, r, 0, 1, 1, 0, 0, 1);
            repeat (7) cycle();
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 149) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
